// File: rtl/ibex_pkg.sv
// Shared core types: FPU operator encoding plus the issue sequencer's state and response types.
package ibex_pkg;

  typedef enum logic [1:0] {
    FP_ALU_ADD = 2'd0,
    FP_ALU_SUB = 2'd1,
    FP_ALU_MUL = 2'd2
  } fp_alu_op_e;

  localparam int unsigned FPU_TAG_W = 4;

  typedef enum logic {
    FPU_SEQ_IDLE = 1'b0,
    FPU_SEQ_BUSY = 1'b1
  } fpu_seq_state_e;

  typedef struct packed {
    logic [15:0]          result;
    logic [FPU_TAG_W-1:0] tag;
  } fpu_rsp_t;

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous response FIFO for the FPU sequencer; head entry is read straight from storage.
module fpu_rsp_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  input  logic           push_i,
  input  fpu_rsp_t       data_i,
  input  logic           pop_i,
  output fpu_rsp_t       data_o,
  output logic [PTR_W:0] count_o,
  output logic           empty_o
);

  fpu_rsp_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full;
  logic             push_en, pop_en;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  // Pop of an empty FIFO or push into a full one is ignored.
  assign push_en = push_i && !full && !flush_i;
  assign pop_en  = pop_i && !empty_o && !flush_i;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_en) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/fpu_req_sequencer.sv
// Issue-side sequencer: registers an op onto the combinational FPU, holds it FPU_LAT cycles,
// then queues {result, tag} into a response FIFO.
module fpu_req_sequencer
  import ibex_pkg::*;
#(
  parameter int unsigned FPU_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 2,
  parameter int unsigned TAG_W     = FPU_TAG_W
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           flush_i,
  // Both channels: a beat transfers on a rising edge where valid && ready are high; the
  // source keeps payload stable until then, and valid never waits on ready.
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  fp_alu_op_e     req_op_i,
  input  logic [15:0]    req_a_i,
  input  logic [15:0]    req_b_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output fp_alu_op_e     fpu_operator_o,
  output logic [15:0]    fpu_operand_a_o,
  output logic [15:0]    fpu_operand_b_o,
  input  logic [15:0]    fpu_result_i,
  output logic           rsp_valid_o,
  input  logic           rsp_ready_i,
  output logic [15:0]    rsp_result_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output fpu_seq_state_e state_o
);

  localparam int unsigned CNT_W  = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;
  localparam int unsigned FCNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FPU_LAT - 1);

  fpu_seq_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  fp_alu_op_e       op_q, op_d;
  logic [15:0]      a_q, a_d, b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic              busy, cnt_zero, slot_free, credit_ok, accept, push;
  logic [FCNT_W-1:0] fifo_count, used;
  logic              fifo_empty;
  fpu_rsp_t          push_data, head;

  assign busy      = (state_q == FPU_SEQ_BUSY);
  assign cnt_zero  = (cnt_q == '0);
  assign slot_free = !busy || cnt_zero;
  // The op completing this cycle already owns a FIFO entry, so every BUSY op is charged;
  // this keeps a back-to-back accept from overrunning a FIFO that is not draining.
  assign used      = fifo_count + FCNT_W'(busy);
  assign credit_ok = (used < FCNT_W'(RSP_DEPTH));

  assign req_ready_o = slot_free && credit_ok && !flush_i;
  assign accept      = req_valid_i && req_ready_o;
  assign push        = busy && cnt_zero && !flush_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    case (state_q)
      FPU_SEQ_IDLE: begin
        if (accept) begin
          state_d = FPU_SEQ_BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      FPU_SEQ_BUSY: begin
        if (!cnt_zero) begin
          cnt_d = cnt_q - 1'b1;
        end else if (accept) begin
          cnt_d = CNT_INIT;
        end else begin
          state_d = FPU_SEQ_IDLE;
        end
      end
      default: state_d = FPU_SEQ_IDLE;
    endcase
    // Operands move only on accept, so they are stable across the multicycle FPU path.
    if (accept) begin
      op_d  = req_op_i;
      a_d   = req_a_i;
      b_d   = req_b_i;
      tag_d = req_tag_i;
    end
    if (flush_i) begin
      state_d = FPU_SEQ_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FPU_SEQ_IDLE;
      cnt_q   <= '0;
      op_q    <= FP_ALU_ADD;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
    end
  end

  assign push_data.result = fpu_result_i;
  assign push_data.tag    = tag_q;

  fpu_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (rsp_ready_i),
    .data_o  (head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  assign fpu_operator_o  = op_q;
  assign fpu_operand_a_o = a_q;
  assign fpu_operand_b_o = b_q;
  assign rsp_valid_o     = !fifo_empty;
  assign rsp_result_o    = head.result;
  assign rsp_tag_o       = head.tag;
  assign state_o         = state_q;

endmodule

// File: tb/tb_fpu_req_sequencer.sv
// Directed bench: two sequencers (FPU_LAT=1 and FPU_LAT=3) each driving a bf16 reference FPU.
module tb_fpu_req_sequencer;
  import ibex_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // ---------------- reference bf16 FPU ----------------
  function automatic real bf_to_r(input logic [15:0] x);
    int          e;
    logic [63:0] bits;
    if (x[14:0] == 15'd0) return 0.0;
    e    = int'(x[14:7]) - 127 + 1023;
    bits = {x[15], e[10:0], x[6:0], 45'd0};
    return $bitstoreal(bits);
  endfunction

  function automatic logic [15:0] r_to_bf(input real r);
    int          e;
    logic [63:0] bits;
    if (r == 0.0) return 16'h0000;
    bits = $realtobits(r);
    e    = int'(bits[62:52]) - 1023 + 127;
    return {bits[63], e[7:0], bits[51:45]};
  endfunction

  function automatic logic [15:0] fpu_model(input fp_alu_op_e op, input logic [15:0] a,
                                            input logic [15:0] b);
    case (op)
      FP_ALU_ADD: return r_to_bf(bf_to_r(a) + bf_to_r(b));
      FP_ALU_SUB: return r_to_bf(bf_to_r(a) - bf_to_r(b));
      FP_ALU_MUL: return r_to_bf(bf_to_r(a) * bf_to_r(b));
      default:    return 16'h0000;
    endcase
  endfunction

  // ---------------- DUT 1: FPU_LAT=1 ----------------
  logic v1, rr1, fl1, rdy1, rv1;
  fp_alu_op_e op1, fop1;
  logic [15:0] a1, b1, fa1, fb1, fres1, rres1;
  logic [3:0] t1, rtag1;
  fpu_seq_state_e st1;
  assign fres1 = fpu_model(fop1, fa1, fb1);

  fpu_req_sequencer #(.FPU_LAT(1), .RSP_DEPTH(2), .TAG_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl1),
    .req_valid_i(v1), .req_ready_o(rdy1), .req_op_i(op1), .req_a_i(a1), .req_b_i(b1),
    .req_tag_i(t1), .fpu_operator_o(fop1), .fpu_operand_a_o(fa1), .fpu_operand_b_o(fb1),
    .fpu_result_i(fres1), .rsp_valid_o(rv1), .rsp_ready_i(rr1), .rsp_result_o(rres1),
    .rsp_tag_o(rtag1), .state_o(st1)
  );

  // ---------------- DUT 3: FPU_LAT=3 ----------------
  logic v3, rr3, fl3, rdy3, rv3;
  fp_alu_op_e op3, fop3;
  logic [15:0] a3, b3, fa3, fb3, fres3, rres3;
  logic [3:0] t3, rtag3;
  fpu_seq_state_e st3;
  assign fres3 = fpu_model(fop3, fa3, fb3);

  fpu_req_sequencer #(.FPU_LAT(3), .RSP_DEPTH(2), .TAG_W(4)) dut3 (
    .clk_i(clk), .rst_i(rst), .flush_i(fl3),
    .req_valid_i(v3), .req_ready_o(rdy3), .req_op_i(op3), .req_a_i(a3), .req_b_i(b3),
    .req_tag_i(t3), .fpu_operator_o(fop3), .fpu_operand_a_o(fa3), .fpu_operand_b_o(fb3),
    .fpu_result_i(fres3), .rsp_valid_o(rv3), .rsp_ready_i(rr3), .rsp_result_o(rres3),
    .rsp_tag_o(rtag3), .state_o(st3)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input fp_alu_op_e op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag);
    v1 = v; op1 = op; a1 = a; b1 = b; t1 = tag;
  endtask

  task automatic drive3(input logic v, input fp_alu_op_e op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag);
    v3 = v; op3 = op; a3 = a; b3 = b; t3 = tag;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    drive1(1'b0, FP_ALU_ADD, 16'h0, 16'h0, 4'h0);
    drive3(1'b0, FP_ALU_ADD, 16'h0, 16'h0, 4'h0);
    rr1 = 1'b0; fl1 = 1'b0; rr3 = 1'b0; fl3 = 1'b0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_rsp_valid", 32'(rv1), 32'd0);
    check("rst_ready",     32'(rdy1), 32'd1);
    check("rst_state",     32'(st1), 32'(FPU_SEQ_IDLE));
    check("rst_op",        32'(fop1), 32'(FP_ALU_ADD));
    check("rst_a",         32'(fa1), 32'h0);
    check("rst_b",         32'(fb1), 32'h0);

    // 1: single ADD, one-cycle latency
    drive1(1'b1, FP_ALU_ADD, 16'h3F80, 16'h4000, 4'd3);
    check("t1_ready", 32'(rdy1), 32'd1);
    step();
    v1 = 1'b0;
    check("t1_busy",      32'(st1), 32'(FPU_SEQ_BUSY));
    check("t1_not_yet",   32'(rv1), 32'd0);
    check("t1_opa",       32'(fa1), 32'h3F80);
    step();
    check("t1_valid",  32'(rv1), 32'd1);
    check("t1_result", 32'(rres1), 32'h4040);
    check("t1_tag",    32'(rtag1), 32'd3);
    check("t1_idle",   32'(st1), 32'(FPU_SEQ_IDLE));
    rr1 = 1'b1;
    step();
    rr1 = 1'b0;
    check("t1_drained", 32'(rv1), 32'd0);

    // 2: back-to-back MUL then SUB, draining every cycle
    rr1 = 1'b1;
    drive1(1'b1, FP_ALU_MUL, 16'h4000, 16'h4040, 4'd5);
    step();
    drive1(1'b1, FP_ALU_SUB, 16'h4040, 16'h3F80, 4'd6);
    check("t2_b2b_ready", 32'(rdy1), 32'd1);
    step();
    v1 = 1'b0;
    check("t2_v0",   32'(rv1), 32'd1);
    check("t2_res0", 32'(rres1), 32'h40C0);
    check("t2_tag0", 32'(rtag1), 32'd5);
    step();
    check("t2_v1",   32'(rv1), 32'd1);
    check("t2_res1", 32'(rres1), 32'h4000);
    check("t2_tag1", 32'(rtag1), 32'd6);
    step();
    check("t2_empty", 32'(rv1), 32'd0);
    rr1 = 1'b0;

    // 3: credits with a stalled response channel
    drive1(1'b1, FP_ALU_ADD, 16'h3F80, 16'h3F80, 4'd1);
    step();
    drive1(1'b1, FP_ALU_ADD, 16'h4000, 16'h4000, 4'd2);
    step();
    drive1(1'b1, FP_ALU_MUL, 16'h4000, 16'h4000, 4'd7);
    check("t3_no_credit_busy", 32'(rdy1), 32'd0);
    step();
    check("t3_no_credit_idle", 32'(rdy1), 32'd0);
    check("t3_head_tag",       32'(rtag1), 32'd1);
    check("t3_head_res",       32'(rres1), 32'h4000);
    rr1 = 1'b1;
    step();
    rr1 = 1'b0;
    check("t3_credit_back", 32'(rdy1), 32'd1);
    check("t3_second_tag",  32'(rtag1), 32'd2);
    check("t3_second_res",  32'(rres1), 32'h4080);
    step();
    v1 = 1'b0;
    check("t3_full_again", 32'(rdy1), 32'd0);
    step();
    rr1 = 1'b1;
    check("t3_still_second", 32'(rtag1), 32'd2);
    step();
    check("t3_third_tag", 32'(rtag1), 32'd7);
    check("t3_third_res", 32'(rres1), 32'h4080);
    step();
    check("t3_no_dup", 32'(rv1), 32'd0);
    rr1 = 1'b0;

    // 5: flush while BUSY with one queued response
    drive1(1'b1, FP_ALU_ADD, 16'h3F80, 16'h3F80, 4'd10);
    step();
    drive1(1'b1, FP_ALU_MUL, 16'h4000, 16'h4000, 4'd11);
    step();
    v1 = 1'b0;
    check("t5_queued", 32'(rv1), 32'd1);
    fl1 = 1'b1;
    check("t5_flush_ready", 32'(rdy1), 32'd0);
    step();
    fl1 = 1'b0;
    check("t5_flushed",   32'(rv1), 32'd0);
    check("t5_idle",      32'(st1), 32'(FPU_SEQ_IDLE));
    check("t5_keep_a",    32'(fa1), 32'h4000);
    check("t5_keep_op",   32'(fop1), 32'(FP_ALU_MUL));
    step(); step();
    check("t5_no_ghost",  32'(rv1), 32'd0);
    check("t5_ready",     32'(rdy1), 32'd1);

    // 6: reset mid-op
    drive1(1'b1, FP_ALU_ADD, 16'h4000, 16'h4040, 4'd12);
    step();
    v1 = 1'b0;
    check("t6_busy", 32'(st1), 32'(FPU_SEQ_BUSY));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rsp_valid", 32'(rv1), 32'd0);
    check("t6_state",     32'(st1), 32'(FPU_SEQ_IDLE));
    check("t6_op",        32'(fop1), 32'(FP_ALU_ADD));
    check("t6_a",         32'(fa1), 32'h0);
    check("t6_b",         32'(fb1), 32'h0);
    step();
    check("t6_no_rsp", 32'(rv1), 32'd0);
    drive1(1'b1, FP_ALU_ADD, 16'h3F80, 16'h4000, 4'd9);
    step();
    v1 = 1'b0;
    step();
    check("t6_after_valid", 32'(rv1), 32'd1);
    check("t6_after_res",   32'(rres1), 32'h4040);
    check("t6_after_tag",   32'(rtag1), 32'd9);

    // 4: FPU_LAT=3 operand hold and sampling point
    drive3(1'b1, FP_ALU_ADD, 16'h4000, 16'h4040, 4'd4);
    check("t4_ready0", 32'(rdy3), 32'd1);
    step();
    drive3(1'b1, FP_ALU_SUB, 16'h4040, 16'h3F80, 4'd8);
    for (int k = 0; k < 2; k++) begin
      check("t4_hold_ready", 32'(rdy3), 32'd0);
      check("t4_hold_a",     32'(fa3), 32'h4000);
      check("t4_hold_b",     32'(fb3), 32'h4040);
      check("t4_hold_valid", 32'(rv3), 32'd0);
      step();
    end
    check("t4_last_ready", 32'(rdy3), 32'd1);
    check("t4_last_a",     32'(fa3), 32'h4000);
    check("t4_last_valid", 32'(rv3), 32'd0);
    step();
    v3 = 1'b0;
    check("t4_valid",  32'(rv3), 32'd1);
    check("t4_result", 32'(rres3), 32'h40A0);
    check("t4_tag",    32'(rtag3), 32'd4);
    check("t4_new_a",  32'(fa3), 32'h4040);
    rr3 = 1'b1;
    step();
    check("t4_gap0", 32'(rv3), 32'd0);
    step();
    check("t4_gap1", 32'(rv3), 32'd0);
    step();
    check("t4_valid2",  32'(rv3), 32'd1);
    check("t4_result2", 32'(rres3), 32'h4000);
    check("t4_tag2",    32'(rtag3), 32'd8);
    step();
    check("t4_drained", 32'(rv3), 32'd0);
    rr3 = 1'b0;

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
